// File: rtl/serial_add_pkg.sv
// Package: serial_add_pkg
// Shared constants for the nibble-serial adder controller.
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit FSM state encodings
//   NIBBLE_W                   : width of one slice pass
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/FA_4_Lookahead.sv
// Module: FA_4_Lookahead
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   A, B  in  4  addends
//   Cin   in  1  carry in
//   S     out 4  sum
//   Cout  out 1  carry out
module FA_4_Lookahead (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is expanded from the slice inputs, so none waits on a lower bit.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Module: nibble_serial_adder_ctrl
// Runs one 4-bit lookahead slice over WIDTH-bit operands, one nibble per clock,
// LSB nibble first, with the carry held in a flop between passes.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub port; subtract = A + ~B + 1).
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, honoured only in IDLE
//   a, b   in   WIDTH  operands, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   sub    in   1      subtract select (SERIAL_ADD_SUB_EN only)
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse, results valid from this cycle
//   sum    out  WIDTH  result, held until the next done
//   cout   out  1      carry out of the MSB nibble (NOT borrow when subtracting)
//   ovf    out  1      signed overflow
module nibble_serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic                      carry;
  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  // Holds the already-computed low nibbles; the final nibble joins on the last pass.
  logic [WIDTH-NIBBLE_W-1:0] sum_sh;

  logic [NIBBLE_W-1:0]       slice_s;
  logic                      slice_c;
  logic [WIDTH-1:0]          sum_nxt;
  logic [WIDTH-1:0]          b_eff;
  logic                      carry_init;

`ifdef SERIAL_ADD_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_eff      = b;
  assign carry_init = cin;
`endif

  FA_4_Lookahead u_slice (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry),
    .S    (slice_s),
    .Cout (slice_c)
  );

  assign sum_nxt = {slice_s, sum_sh};

  // NOTE: every register here is assigned with <= so all flops update from
  // the same pre-edge values; blocking = would make later reads see new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= carry_init;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= {{NIBBLE_W{1'b0}}, a_sh[WIDTH-1:NIBBLE_W]};
          b_sh   <= {{NIBBLE_W{1'b0}}, b_sh[WIDTH-1:NIBBLE_W]};
          sum_sh <= sum_nxt[WIDTH-1:NIBBLE_W];
          carry  <= slice_c;
          idx    <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            // Results are registered on entry to DONE so they are valid with the pulse.
            // On the last pass the slice holds the operand MSBs in bit 3.
            sum   <= sum_nxt;
            cout  <= slice_c;
            ovf   <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
                     (slice_s[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (WIDTH=16), directed vectors.
// Define SERIAL_ADD_SUB_EN to include the subtract scenarios.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Launches one op and waits (bounded) for done, sampling on negedges.
  // lat counts negedges after the accepting edge up to the one showing done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs to show captured copies are used.
    a = 16'hDEAD; b = 16'hBEEF; cin = ~cv;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] es,
                              input logic ec, input logic eo, input int lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL %s latency got %0d want 5", name, lat);
    end
    checks++;
    if (sum !== es) begin
      errors++;
      $display("FAIL %s sum got %h want %h", name, sum, es);
    end
    checks++;
    if (cout !== ec) begin
      errors++;
      $display("FAIL %s cout got %b want %b", name, cout, ec);
    end
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL %s ovf got %b want %b", name, ovf, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf, sum} !== {4'b0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy, done, cout, ovf, sum);
    end
  endtask

  task automatic test_add_basic();
    int lat, bcnt;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bcnt);
    check_result("add_1234_4321", 16'h5555, 1'b0, 1'b0, lat);
    checks++;
    if (bcnt !== 4) begin
      errors++;
      $display("FAIL busy_cycles got %0d want 4", bcnt);
    end
    // done must be a single-cycle pulse; sum must hold afterwards.
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || sum !== 16'h5555) begin
      errors++;
      $display("FAIL done_pulse got done=%b sum=%h want done=0 sum=5555", done, sum);
    end
  endtask

  task automatic test_carry_chain();
    int lat, bcnt;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
    check_result("carry_ffff_0001", 16'h0000, 1'b1, 1'b0, lat);
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, lat, bcnt);
    check_result("ovf_7fff_cin", 16'h8000, 1'b0, 1'b1, lat);
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 16'h1111; b = 16'h0222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0F0F; start = 1'b1;   // mid-RUN request
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_result("ignore_start", 16'h1333, 1'b0, 1'b0, lat);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sum !== 16'h1333) begin
      errors++;
      $display("FAIL not_queued got busy=%b sum=%h want busy=0 sum=1333", busy, sum);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int last = -1;
    int ndone = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    while (ndone < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (done) begin
        checks++;
        if (sum !== 16'h3333) begin
          errors++;
          $display("FAIL b2b_sum got %h want 3333", sum);
        end
        if (last >= 0) begin
          checks++;
          if (t - last !== 6) begin
            errors++;
            $display("FAIL b2b_interval got %0d want 6", t - last);
          end
        end
        last = t;
        ndone++;
      end
    end
    checks++;
    if (ndone !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", ndone);
    end
    start = 1'b0;
    t = 0;
    while ((busy || done) && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt;
    // sum currently 3333 from the previous op.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);               // accepted, idx=0
    start = 1'b0;
    repeat (2) @(negedge clk);    // idx=2
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, ovf, sum} !== {4'b0000, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset got done=%b want 0", done);
      end
    end
    run_op(16'h0101, 16'h0202, 1'b0, 1'b0, lat, bcnt);
    check_result("after_reset", 16'h0303, 1'b0, 1'b0, lat);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat, bcnt;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bcnt);
    check_result("sub_5_7", 16'hFFFE, 1'b0, 1'b0, lat);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, bcnt);
    check_result("sub_7_5", 16'h0002, 1'b1, 1'b0, lat);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt);
    check_result("sub_8000_1", 16'h7FFF, 1'b1, 1'b1, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
